// File: rtl/apb_sched_pkg.sv
//============================================================================
// Module      : apb_sched_pkg
// Description : Shared types and constants for the APB slave scheduler:
//               FSM state encoding, slot-index width, completion/error
//               source encoding and a saturating-increment helper.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package apb_sched_pkg;

    // Number of address MSBs used to pick one of the four slave slots
    localparam int SLOT_W = 2;

    // Width of the saturating error counter
    localparam int ERR_CNT_W = 8;

    // Width of the wait-state counter; TIMEOUT is limited to 255
    localparam int WAIT_CNT_W = 8;

    // Transfer-phase encoding seen by the scheduler FSM
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    // Who terminated the current transfer (slave, unmapped slot, timeout)
    typedef enum logic [1:0] {
        SRC_SLV   = 2'd0,
        SRC_UNMAP = 2'd1,
        SRC_TOUT  = 2'd2
    } err_src_e;

    // Increment that holds at all-ones instead of wrapping
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == {ERR_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/apb_wait_timer.sv
//============================================================================
// Module      : apb_wait_timer
// Description : Wait-state counter for one APB transfer. Cleared in the
//               setup cycle, advanced on every ACCESS cycle in which the
//               selected slave is not ready. 'hit' flags the ACCESS cycle
//               on which the slave has used up its TIMEOUT cycles.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module apb_wait_timer
    import apb_sched_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    // Counter value present on the TIMEOUT-th ACCESS cycle
    localparam logic [WAIT_CNT_W-1:0] c_LAST = WAIT_CNT_W'(TIMEOUT - 1);
    localparam logic [WAIT_CNT_W-1:0] c_MAX  = {WAIT_CNT_W{1'b1}};

    logic [WAIT_CNT_W-1:0] r_cnt;

    // Count not-ready ACCESS cycles; clear wins, never wrap past all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != c_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Timeout only when this cycle is itself another wait cycle
    assign hit = inc & (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/apb_slave_sched.sv
//============================================================================
// Module      : apb_slave_sched
// Description : APB decoder/scheduler between one bridge master port and
//               four slave slots. Decodes the slot from the address MSBs,
//               answers unmapped slots with an immediate error, terminates
//               stalled slaves with a timeout error, and keeps a small
//               registered error log (pulse, saturating count, address).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module apb_slave_sched
    import apb_sched_pkg::*;
#(
    parameter int              ADDRWIDTH = 16,
    parameter int              NSLV      = 4,
    parameter logic [NSLV-1:0] SLV_EN    = 4'b0111,
    parameter int              TIMEOUT   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    // master side (from the bridge)
    input  logic                   m_psel,
    input  logic                   m_penable,
    input  logic                   m_pwrite,
    input  logic [ADDRWIDTH-1:0]   m_paddr,
    input  logic [31:0]            m_pwdata,
    output logic [31:0]            m_prdata,
    output logic                   m_pready,
    output logic                   m_pslverr,
    // slave side
    output logic [NSLV-1:0]        s_psel,
    output logic                   s_penable,
    output logic                   s_pwrite,
    output logic [ADDRWIDTH-1:0]   s_paddr,
    output logic [31:0]            s_pwdata,
    input  logic [NSLV*32-1:0]     s_prdata,
    input  logic [NSLV-1:0]        s_pready,
    input  logic [NSLV-1:0]        s_pslverr,
    // error log
    output logic                   err_pulse,
    output logic [ERR_CNT_W-1:0]   err_count,
    output logic [ADDRWIDTH-1:0]   err_addr
);

    localparam logic [1:0] c_ST_IDLE   = ST_IDLE;
    localparam logic [1:0] c_ST_SETUP  = ST_SETUP;
    localparam logic [1:0] c_ST_ACCESS = ST_ACCESS;

    logic [1:0]            r_state;
    logic [1:0]            w_cur;
    logic [1:0]            w_nxt;
    logic [SLOT_W-1:0]     w_idx;
    logic                  w_mapped;
    logic                  w_slv_rdy;
    logic                  w_slv_err;
    logic [31:0]           w_slv_rdata;
    logic [31:0]           w_rdata_arr [NSLV];
    logic                  w_sel_act;
    logic                  w_wait_clr;
    logic                  w_wait_inc;
    logic                  w_hit;
    logic                  w_done;
    logic                  w_pslverr;
    logic                  w_err_ev;
    err_src_e              w_src;
    logic                  r_err_pulse;
    logic [ERR_CNT_W-1:0]  r_err_count;
    logic [ADDRWIDTH-1:0]  r_err_addr;

    // Slot decode from the address MSBs
    assign w_idx    = m_paddr[ADDRWIDTH-1 -: SLOT_W];
    assign w_mapped = SLV_EN[w_idx];

    // Unpack the flat slave read-data bus into per-slot words
    for (genvar gi = 0; gi < NSLV; gi++) begin : g_rdata
        assign w_rdata_arr[gi] = s_prdata[32*gi +: 32];
    end

    assign w_slv_rdy   = s_pready[w_idx];
    assign w_slv_err   = s_pslverr[w_idx];
    assign w_slv_rdata = w_rdata_arr[w_idx];

    // The setup phase is recognised in the same cycle the master presents
    // it, so SETUP is derived from IDLE plus the inputs rather than stored;
    // this keeps s_psel aligned with the master's setup cycle, and makes a
    // back-to-back setup after a completion fall out of IDLE naturally.
    always_comb begin
        w_cur = r_state;
        if ((r_state == c_ST_IDLE) && m_psel && !m_penable) begin
            w_cur = c_ST_SETUP;
        end
    end

    // Next phase: setup always advances, access ends on completion or abort
    always_comb begin
        w_nxt = c_ST_IDLE;
        case (w_cur)
            c_ST_SETUP:  w_nxt = c_ST_ACCESS;
            c_ST_ACCESS: w_nxt = (w_done || !m_psel) ? c_ST_IDLE : c_ST_ACCESS;
            default:     w_nxt = c_ST_IDLE;
        endcase
    end

    // Phase register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    // Wait-state timer: cleared in setup, counts stalled ACCESS cycles
    assign w_wait_clr = (w_cur == c_ST_SETUP);
    assign w_wait_inc = (w_cur == c_ST_ACCESS) & w_mapped & ~w_slv_rdy;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk (clk),
        .rst (rst),
        .clr (w_wait_clr),
        .inc (w_wait_inc),
        .hit (w_hit)
    );

    // Completion source; a slave ready beats a coincident timeout
    always_comb begin
        w_done = 1'b0;
        w_src  = SRC_SLV;
        if (w_cur == c_ST_ACCESS) begin
            if (!w_mapped) begin
                w_done = 1'b1;
                w_src  = SRC_UNMAP;
            end else if (w_slv_rdy) begin
                w_done = 1'b1;
                w_src  = SRC_SLV;
            end else if (w_hit) begin
                w_done = 1'b1;
                w_src  = SRC_TOUT;
            end
        end
    end

    assign w_pslverr = w_done & ((w_src == SRC_SLV) ? w_slv_err : 1'b1);
    assign w_err_ev  = w_done & w_pslverr;

    // Master-side response, combinational from state and slave inputs
    assign m_pready  = w_done;
    assign m_pslverr = w_pslverr;
    assign m_prdata  = (w_done && (w_src == SRC_SLV)) ? w_slv_rdata : 32'h0;

    // Broadcast signals; enable is held low whenever no transfer is active
    assign s_paddr   = m_paddr;
    assign s_pwrite  = m_pwrite;
    assign s_pwdata  = m_pwdata;
    assign s_penable = (w_cur != c_ST_IDLE) ? m_penable : 1'b0;

    // One-hot select for a mapped slot during setup/access only
    assign w_sel_act = (w_cur != c_ST_IDLE) & w_mapped & m_psel;

    for (genvar gi = 0; gi < NSLV; gi++) begin : g_psel
        assign s_psel[gi] = w_sel_act & (w_idx == SLOT_W'(gi));
    end

    // Error log: one-cycle strobe, saturating count, last failing address
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
            r_err_addr  <= '0;
        end else begin
            r_err_pulse <= w_err_ev;
            if (w_err_ev) begin
                r_err_count <= sat_inc(r_err_count);
                r_err_addr  <= m_paddr;
            end
        end
    end

    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;
    assign err_addr  = r_err_addr;

endmodule

`default_nettype wire

// File: tb/tb_apb_slave_sched.sv
//============================================================================
// Module      : tb_apb_slave_sched
// Description : Self-checking bench for apb_slave_sched. Expected responses
//               come from a per-transfer model (completion cycle, error flag
//               and data derived from slot map, wait count and TIMEOUT) and
//               a saturating error-log model.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_apb_slave_sched;

    localparam int         AW = 16;
    localparam int         NS = 4;
    localparam logic [3:0] EN = 4'b0111;
    localparam int         TO = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              m_psel, m_penable, m_pwrite;
    logic [AW-1:0]     m_paddr;
    logic [31:0]       m_pwdata;
    logic [31:0]       m_prdata;
    logic              m_pready, m_pslverr;
    logic [NS-1:0]     s_psel;
    logic              s_penable, s_pwrite;
    logic [AW-1:0]     s_paddr;
    logic [31:0]       s_pwdata;
    logic [NS*32-1:0]  s_prdata;
    logic [NS-1:0]     s_pready, s_pslverr;
    logic              err_pulse;
    logic [7:0]        err_count;
    logic [AW-1:0]     err_addr;

    int n_tests = 0;
    int n_fail  = 0;

    // error-log model
    bit          mp_pulse = 1'b0;
    logic [7:0]  mp_cnt   = 8'd0;
    logic [15:0] mp_addr  = 16'd0;
    bit          ev_pend  = 1'b0;
    logic [15:0] ev_addr  = 16'd0;

    always #5 clk = ~clk;

    apb_slave_sched #(
        .ADDRWIDTH (AW),
        .NSLV      (NS),
        .SLV_EN    (EN),
        .TIMEOUT   (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_psel    (m_psel),
        .m_penable (m_penable),
        .m_pwrite  (m_pwrite),
        .m_paddr   (m_paddr),
        .m_pwdata  (m_pwdata),
        .m_prdata  (m_prdata),
        .m_pready  (m_pready),
        .m_pslverr (m_pslverr),
        .s_psel    (s_psel),
        .s_penable (s_penable),
        .s_pwrite  (s_pwrite),
        .s_paddr   (s_paddr),
        .s_pwdata  (s_pwdata),
        .s_prdata  (s_prdata),
        .s_pready  (s_pready),
        .s_pslverr (s_pslverr),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .err_addr  (err_addr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and update the error-log model for that edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) begin
            mp_pulse = 1'b0;
            mp_cnt   = 8'd0;
            mp_addr  = 16'd0;
        end else begin
            mp_pulse = ev_pend;
            if (ev_pend) begin
                if (mp_cnt != 8'd255) mp_cnt = mp_cnt + 8'd1;
                mp_addr = ev_addr;
            end
        end
        ev_pend = 1'b0;
    endtask

    // Let driven inputs settle, then check the registered error log
    task automatic settle();
        #1;
        chk("err_pulse", err_pulse, mp_pulse);
        chk("err_count", err_count, mp_cnt);
        chk("err_addr",  err_addr,  mp_addr);
    endtask

    // Random slave bus with the given response on one slot
    task automatic drive_slv(input int slot, input bit rdy, input bit serr, input logic [31:0] rd);
        s_pready  = 4'($urandom);
        s_pslverr = 4'($urandom);
        for (int i = 0; i < NS; i++) s_prdata[32*i +: 32] = $urandom;
        s_pready[slot] = rdy;
        if (rdy) begin
            s_pslverr[slot]          = serr;
            s_prdata[32*slot +: 32]  = rd;
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] sel, input logic pen,
                           input logic rdy, input logic err, input logic [31:0] d);
        chk({tag, "_psel"},    s_psel,    sel);
        chk({tag, "_penable"}, s_penable, pen);
        chk({tag, "_pready"},  m_pready,  rdy);
        chk({tag, "_pslverr"}, m_pslverr, err);
        chk({tag, "_prdata"},  m_prdata,  d);
    endtask

    // One full transfer; slave becomes ready after 'waits' wait cycles
    task automatic xfer(input string tag, input logic [15:0] addr, input logic wr,
                        input logic [31:0] wd, input int waits, input logic serr,
                        input logic [31:0] rd, input bit hold);
        int          slot;
        bit          mapped;
        int          c;
        bit          e;
        logic [31:0] d;
        logic [3:0]  sel;
        slot   = int'(addr[15:14]);
        mapped = EN[slot];
        sel    = mapped ? (4'b0001 << slot) : 4'b0000;
        if (!mapped) begin
            c = 1; e = 1'b1; d = 32'h0;
        end else if (waits < TO) begin
            c = waits + 1; e = serr; d = rd;
        end else begin
            c = TO; e = 1'b1; d = 32'h0;
        end
        tick();
        m_psel = 1'b1; m_penable = 1'b0; m_pwrite = wr; m_paddr = addr; m_pwdata = wd;
        drive_slv(slot, 1'($urandom), serr, rd);
        settle();
        chk_out({tag, "_setup"}, sel, 1'b0, 1'b0, 1'b0, 32'h0);
        chk({tag, "_paddr"},  s_paddr,  addr);
        chk({tag, "_pwdata"}, s_pwdata, wd);
        chk({tag, "_pwrite"}, s_pwrite, wr);
        for (int k = 1; k <= c; k++) begin
            tick();
            m_penable = 1'b1;
            drive_slv(slot, mapped ? (k > waits) : 1'($urandom), serr, rd);
            settle();
            if (k == c) begin
                chk_out({tag, "_done"}, sel, 1'b1, 1'b1, e, d);
                ev_pend = e;
                ev_addr = addr;
            end else begin
                chk_out({tag, "_wait"}, sel, 1'b1, 1'b0, 1'b0, 32'h0);
            end
        end
        if (hold) begin
            // master lingers in access; a late slave response must be ignored
            tick();
            drive_slv(slot, 1'b1, 1'b1, 32'hDEAD_BEEF);
            settle();
            chk_out({tag, "_after"}, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);
        end
    endtask

    task automatic idle_cyc(input string tag);
        tick();
        m_psel = 1'b0; m_penable = 1'b0; m_paddr = 16'($urandom);
        drive_slv(int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), $urandom);
        settle();
        chk_out(tag, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        m_psel = 1'b0; m_penable = 1'b0; m_pwrite = 1'b0; m_paddr = '0; m_pwdata = '0;
        s_prdata = '0; s_pready = '0; s_pslverr = '0;
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk_out("reset", 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);

        // directed transfers
        xfer("wr_slot0", 16'h0010, 1'b1, 32'hA5A5_0001, 2, 1'b0, 32'h0BAD_0001, 1'b0);
        idle_cyc("idle_a");
        xfer("rd_slot2", 16'h8004, 1'b0, 32'h0, 0, 1'b0, 32'h1234_5678, 1'b0);
        idle_cyc("idle_b");
        xfer("unmap3", 16'hC000, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0);
        idle_cyc("idle_c");
        chk("unmap3_cnt",  err_count, 8'd1);
        chk("unmap3_addr", err_addr,  16'hC000);
        xfer("tout_slot1", 16'h4010, 1'b0, 32'h0, 1000, 1'b0, 32'h0, 1'b1);
        idle_cyc("idle_d");
        xfer("edge_slot1", 16'h4020, 1'b0, 32'h0, TO - 1, 1'b0, 32'hCAFE_F00D, 1'b0);
        idle_cyc("idle_e");
        chk("edge_cnt", err_count, 8'd2);
        xfer("b2b_a", 16'h0100, 1'b1, 32'h1111_2222, 1, 1'b0, 32'h3333_4444, 1'b0);
        xfer("b2b_b", 16'h8100, 1'b0, 32'h0, 0, 1'b1, 32'h5555_6666, 1'b0);
        idle_cyc("idle_f");

        // randomized transfers
        for (int n = 0; n < 40; n++) begin
            xfer("rnd", 16'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 20)),
                 1'($urandom), $urandom, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) idle_cyc("rnd_idle");
        end

        // counter saturation
        for (int n = 0; n < 300; n++) begin
            xfer("sat", {2'b11, 14'($urandom)}, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0);
        end
        idle_cyc("idle_g");
        chk("sat_cnt", err_count, 8'd255);

        // reset in the fifth ACCESS cycle of a stalled transfer
        tick();
        m_psel = 1'b1; m_penable = 1'b0; m_pwrite = 1'b1; m_paddr = 16'h4444; m_pwdata = 32'h5555_AAAA;
        drive_slv(1, 1'b0, 1'b0, 32'h0);
        settle();
        for (int k = 1; k <= 5; k++) begin
            tick();
            m_penable = 1'b1;
            drive_slv(1, 1'b0, 1'b0, 32'h0);
            if (k == 5) rst = 1'b1;
            settle();
            chk_out("rst_acc", 4'b0010, 1'b1, 1'b0, 1'b0, 32'h0);
        end
        tick();
        rst = 1'b0;
        s_pready = '1; s_pslverr = '1;
        settle();
        chk_out("rst_after", 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("rst_cnt", err_count, 8'd0);
        tick();
        m_psel = 1'b0; m_penable = 1'b0; m_pwrite = 1'b0; m_paddr = '0; m_pwdata = '0;
        s_prdata = '0; s_pready = '0; s_pslverr = '0;
        settle();
        chk_out("rst_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("rst_paddr",  s_paddr,  16'h0);
        chk("rst_pwdata", s_pwdata, 32'h0);
        chk("rst_pwrite", s_pwrite, 1'b0);
        chk("rst_eaddr",  err_addr, 16'h0);

        // recovery after reset
        xfer("post_rst", 16'h8008, 1'b0, 32'h0, 3, 1'b0, 32'h7777_8888, 1'b0);
        idle_cyc("idle_h");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
